// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data-side memory block: MMIO address map,
// STATUS bit layout and TX FIFO geometry.
package mmio_pkg;

  localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_000C;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 3;
  localparam int ST_CNT_MSB = 5;

  localparam int TXF_DEPTH = 4;
  localparam int TXF_PTR_W = 2;
  localparam int TXF_CNT_W = 3;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_RAM    = 3'd1,
    SEL_LED    = 3'd2,
    SEL_CYCLES = 3'd3,
    SEL_TXDATA = 3'd4,
    SEL_STATUS = 3'd5
  } sel_e;

  // Full 32-bit decode; anything outside RAM and the four registers is a hole.
  function automatic sel_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] ram_bytes);
    sel_e sel;
    if (addr < ram_bytes) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_LED:    sel = SEL_LED;
        ADDR_CYCLES: sel = SEL_CYCLES;
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_STATUS: sel = SEL_STATUS;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// Four-entry circular byte FIFO draining to a valid/ready sink.
// A push into a full FIFO is only accepted if the head leaves in the same cycle.
module tx_fifo
  import mmio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [7:0]           din,
  input  logic                 pop_ready,
  output logic [7:0]           dout,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic [TXF_CNT_W-1:0] count,
  output logic                 overflow_set
);

  logic [7:0]           mem_q [TXF_DEPTH];
  logic [7:0]           mem_d [TXF_DEPTH];
  logic [TXF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TXF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TXF_CNT_W-1:0] count_q, count_d;
  logic                 pop_s;
  logic                 accept_s;

  // Handshake decode, pointer/count next-state and head presentation.
  always_comb begin
    valid        = (count_q != 3'd0);
    full         = (count_q == 3'(TXF_DEPTH));
    empty        = (count_q == 3'd0);
    count        = count_q;
    pop_s        = valid && pop_ready;
    accept_s     = push && (!full || pop_s);
    overflow_set = push && full && !pop_s;
    dout         = valid ? mem_q[rd_ptr_q] : 8'd0;

    mem_d = mem_q;
    if (accept_s) begin
      mem_d[wr_ptr_q] = din;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end

    wr_ptr_d = accept_s ? (wr_ptr_q + 2'd1) : wr_ptr_q;
    rd_ptr_d = pop_s    ? (rd_ptr_q + 2'd1) : rd_ptr_q;

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards contents immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TXF_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus an MMIO page
// holding LED, free-running cycle counter, TX FIFO and its status.
module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      aluout,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  sel_e                 sel_s;
  logic [AW-1:0]        ram_idx_s;
  logic                 ram_we_s;
  logic                 push_s;
  logic [31:0]          led_ext_s;
  logic [31:0]          status_s;

  logic [31:0]          ram_q [DEPTH];
  logic [LED_W-1:0]     led_q, led_d;
  logic [31:0]          cyc_q, cyc_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [TXF_CNT_W-1:0] fifo_count_s;
  logic                 fifo_ovf_set_s;

  tx_fifo u_tx_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push_s),
    .din          (writedata[7:0]),
    .pop_ready    (tx_ready),
    .dout         (tx_data),
    .valid        (tx_valid),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .count        (fifo_count_s),
    .overflow_set (fifo_ovf_set_s)
  );

  // Address decode, register next-state and the combinational read mux.
  always_comb begin
    sel_s     = decode_addr(aluout, RAM_BYTES);
    ram_idx_s = aluout[AW+1:2];
    ram_we_s  = memwrite && (sel_s == SEL_RAM);
    push_s    = memwrite && (sel_s == SEL_TXDATA);

    led_d = (memwrite && sel_s == SEL_LED) ? writedata[LED_W-1:0] : led_q;
    // A CYCLES store replaces that cycle's increment.
    cyc_d = (memwrite && sel_s == SEL_CYCLES) ? writedata : (cyc_q + 32'd1);

    // Clear first so a same-cycle overflowing push still leaves the flag set.
    ovf_d = ovf_q;
    if (memwrite && sel_s == SEL_STATUS) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (fifo_ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    led_ext_s              = 32'd0;
    led_ext_s[LED_W-1:0]   = led_q;

    status_s                         = 32'd0;
    status_s[ST_FULL]                = fifo_full_s;
    status_s[ST_EMPTY]               = fifo_empty_s;
    status_s[ST_OVF]                 = ovf_q;
    status_s[ST_CNT_MSB:ST_CNT_LSB]  = fifo_count_s;

    case (sel_s)
      SEL_RAM:    readdata = ram_q[ram_idx_s];
      SEL_LED:    readdata = led_ext_s;
      SEL_CYCLES: readdata = cyc_q;
      SEL_STATUS: readdata = status_s;
      default:    readdata = 32'd0;
    endcase

    led = led_q;
  end

  // RAM has no reset so its contents survive a core reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= writedata;
    end
  end

  // MMIO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
      cyc_q <= 32'd0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: directed scenarios followed by random
// traffic, checked against a queue/array reference model of the address map.
module tb_data_mem_mmio;
  import mmio_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LED_W = 8;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             memwrite = 1'b0;
  logic [31:0]      aluout = 32'd0;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic [LED_W-1:0] led;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b0;

  data_mem_mmio #(.DEPTH(DEPTH), .LED_W(LED_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int compares = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0]      m_ram [int];
  logic [LED_W-1:0] m_led = '0;
  logic [31:0]      m_cyc = 32'd0;
  logic [7:0]       m_fifo [$];
  bit               m_ovf = 1'b0;

  // Scoreboard queues
  logic [31:0] exp_rd [$];
  string       rd_name [$];
  logic [7:0]  exp_tx [$];
  bit          chk_rd = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    int n;
    n = m_fifo.size();
    v = 32'd0;
    if (a < RAM_BYTES) begin
      if (m_ram.exists(int'(a >> 2))) begin
        v = m_ram[int'(a >> 2)];
        return 1'b1;
      end
      return 1'b0;
    end
    case (a)
      ADDR_LED:    v = 32'(m_led);
      ADDR_CYCLES: v = m_cyc;
      ADDR_STATUS: v = 32'(n) * 32'd8 + (m_ovf ? 32'd4 : 32'd0)
                       + ((n == 0) ? 32'd2 : 32'd0) + ((n == 4) ? 32'd1 : 32'd0);
      default:     v = 32'd0;
    endcase
    return 1'b1;
  endfunction

  // One clock cycle of core traffic; queue the expected read, advance the model.
  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit chk, input string name);
    logic [31:0] v;
    bit known, pop, full;
    memwrite  = we;
    aluout    = a;
    writedata = d;
    tx_ready  = rdy;
    known = model_read(a, v);
    if (chk && known) begin
      exp_rd.push_back(v);
      rd_name.push_back(name);
      chk_rd = 1'b1;
    end else begin
      chk_rd = 1'b0;
    end
    pop  = (m_fifo.size() != 0) && rdy;
    full = (m_fifo.size() == 4);
    if (pop) m_fifo.delete(0);
    if (we) begin
      if (a < RAM_BYTES) m_ram[int'(a >> 2)] = d;
      else if (a == ADDR_LED) m_led = d[LED_W-1:0];
      else if (a == ADDR_STATUS) m_ovf = 1'b0;
      else if (a == ADDR_TXDATA) begin
        if (full && !pop) m_ovf = 1'b1;
        else begin
          m_fifo.push_back(d[7:0]);
          exp_tx.push_back(d[7:0]);
        end
      end
    end
    m_cyc = (we && a == ADDR_CYCLES) ? d : m_cyc + 32'd1;
    vectors++;
    @(posedge clk);
    #1;
    chk_rd = 1'b0;
  endtask

  task automatic do_reset();
    memwrite = 1'b0;
    tx_ready = 1'b0;
    reset    = 1'b0;
    #1;
    check32("rst_tx_valid", 32'(tx_valid), 32'd0);
    check32("rst_tx_data", 32'(tx_data), 32'd0);
    check32("rst_led", 32'(led), 32'd0);
    m_led = '0;
    m_cyc = 32'd0;
    m_ovf = 1'b0;
    m_fifo.delete();
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_tx.size() != 0; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "idle");
    check32("drain_left", 32'(exp_tx.size()), 32'd0);
  endtask

  // Monitor: compare every flagged read and every accepted sink byte.
  always @(negedge clk) begin
    if (chk_rd) begin
      check32(rd_name.pop_front(), readdata, exp_rd.pop_front());
    end
    if (reset && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        compares++;
        miscompares++;
        $display("FAIL tx_extra: got %h, expected no byte", tx_data);
      end else begin
        check32("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int sel;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Counter start, load and wrap
    step(1'b0, ADDR_CYCLES, 32'd0, 1'b0, 1'b1, "cyc0");
    repeat (4) step(1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "idle");
    step(1'b0, ADDR_CYCLES, 32'd0, 1'b0, 1'b1, "cyc5");
    step(1'b1, ADDR_CYCLES, 32'hFFFF_FFFE, 1'b0, 1'b1, "cyc_wr");
    step(1'b0, ADDR_CYCLES, 32'd0, 1'b0, 1'b1, "cyc_fe");
    step(1'b0, ADDR_CYCLES, 32'd0, 1'b0, 1'b1, "cyc_ff");
    step(1'b0, ADDR_CYCLES, 32'd0, 1'b0, 1'b1, "cyc_wrap");

    // RAM, ignored low bits, holes, top boundary
    step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, "st10");
    step(1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, "ld10");
    step(1'b0, 32'h0000_0013, 32'd0, 1'b0, 1'b1, "ld13");
    step(1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b1, "ld_hole");
    step(1'b1, RAM_BYTES - 32'd4, 32'h1234_5678, 1'b0, 1'b0, "st_top");
    step(1'b0, RAM_BYTES - 32'd1, 32'd0, 1'b0, 1'b1, "ld_top");
    step(1'b1, RAM_BYTES, 32'hCAFE_F00D, 1'b0, 1'b1, "wr_past_ram");
    step(1'b0, RAM_BYTES, 32'd0, 1'b0, 1'b1, "ld_past_ram");
    step(1'b0, ADDR_TXDATA, 32'd0, 1'b0, 1'b1, "ld_txdata");

    // Overflow with a stalled sink, then clear
    for (int i = 0; i < 5; i++) step(1'b1, ADDR_TXDATA, 32'h41 + 32'(i), 1'b0, 1'b0, "push");
    step(1'b0, ADDR_STATUS, 32'd0, 1'b0, 1'b1, "status_ovf");
    check32("head_held", 32'(tx_data), 32'h41);
    step(1'b1, ADDR_STATUS, 32'd0, 1'b0, 1'b0, "status_clr");
    step(1'b0, ADDR_STATUS, 32'd0, 1'b0, 1'b1, "status_clr_rd");
    // Push into full FIFO while the sink pops
    step(1'b1, ADDR_TXDATA, 32'h46, 1'b1, 1'b0, "push_full_pop");
    step(1'b0, ADDR_STATUS, 32'd0, 1'b1, 1'b1, "status_full_pop");
    drain();
    step(1'b0, ADDR_STATUS, 32'd0, 1'b0, 1'b1, "status_empty");

    // LED width truncation and mid-stream reset
    step(1'b1, ADDR_LED, 32'h1A5, 1'b0, 1'b0, "led_wr");
    check32("led_port", 32'(led), 32'hA5);
    step(1'b0, ADDR_LED, 32'd0, 1'b0, 1'b1, "led_rd");
    for (int i = 0; i < 3; i++) step(1'b1, ADDR_TXDATA, 32'h60 + 32'(i), 1'b0, 1'b0, "push");
    do_reset();
    step(1'b0, ADDR_STATUS, 32'd0, 1'b0, 1'b1, "status_after_rst");
    step(1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b1, "ram_kept");
    step(1'b0, ADDR_LED, 32'd0, 1'b0, 1'b1, "led_after_rst");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 8);
      d = $urandom;
      case (sel)
        0, 1:    a = 32'($urandom_range(0, 63));
        2:       a = ADDR_LED;
        3:       a = ADDR_CYCLES;
        4, 5:    a = ADDR_TXDATA;
        6:       a = ADDR_STATUS;
        7:       a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_0010 : RAM_BYTES + 32'($urandom_range(0, 3));
        default: a = RAM_BYTES - 32'd4 + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      step(($urandom_range(0, 2) == 0), a, d, ($urandom_range(0, 1) == 1), 1'b1, "rand_rd");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
